// File: rtl/scoreboard_warp_param.sv
// Per-warp issue scoreboard: tracks DEPTH in-flight instructions and flags RAW/WAW/WAR hazards.
// Optional stuck-entry watchdog is compiled in with `define SCB_WATCHDOG_EN.
module scoreboard_warp_param #(
    parameter int DEPTH   = 4,
    parameter int REG_W   = 5,
    parameter int NUM_WB  = 1,
    parameter int TIMEOUT = 1023,
    localparam int IDW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_W-1:0]      Src1,
    input  logic [REG_W-1:0]      Src2,
    input  logic [REG_W-1:0]      Dst,
    input  logic                  Src1_Valid,
    input  logic                  Src2_Valid,
    input  logic                  Dst_Valid,
    input  logic                  RP_Grt,
    input  logic                  Replayable,
    input  logic                  Replay_Complete,
    input  logic [IDW-1:0]        Replay_Complete_ScbID,
    input  logic                  Replay_Complete_SW_LWbar,
    input  logic                  Clear_Valid_Br,
    input  logic [IDW-1:0]        Clear_ScbID_Br,
    input  logic [NUM_WB-1:0]     Clear_Valid_regwr,
    input  logic [NUM_WB*IDW-1:0] Clear_ScbID_regwr,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Dependent,
    output logic [IDW-1:0]        ScbID_Scb_IB,
    output logic [DEPTH-1:0]      Dep_Mask,
    output logic [IDW:0]          Occupancy,
    output logic                  Timeout,
    output logic [IDW-1:0]        Timeout_ScbID
);

    // Handshake: RP_Grt is a single-cycle allocate strobe; it takes effect only when
    // Full is low in the same cycle, and the entry used is the ScbID_Scb_IB shown then.

    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] done_q;
    logic [DEPTH-1:0] wb_seen_q;
    logic [IDW:0]     occ_q;

    logic [REG_W-1:0] dst_q  [DEPTH];
    logic [REG_W-1:0] src1_q [DEPTH];
    logic [REG_W-1:0] src2_q [DEPTH];
    logic [DEPTH-1:0] dst_v_q;
    logic [DEPTH-1:0] src1_v_q;
    logic [DEPTH-1:0] src2_v_q;

    logic [DEPTH-1:0] br_hit;
    logic [DEPTH-1:0] sw_hit;
    logic [DEPTH-1:0] lw_hit;
    logic [DEPTH-1:0] wb_hit;
    logic [DEPTH-1:0] free_hit;
    logic [DEPTH-1:0] valid_clr;
    logic [DEPTH-1:0] alloc_oh;
    logic [DEPTH-1:0] valid_next;
    logic [DEPTH-1:0] hazard;
    logic [IDW-1:0]   alloc_id;
    logic             full_clr;
    logic             alloc_fire;
    logic [IDW:0]     occ_next;

    // An LW entry needs both its writeback and its replay completion, in either order,
    // before it frees; a writeback and a replay completion in the same cycle count as both.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            br_hit[i] = Clear_Valid_Br && (Clear_ScbID_Br == IDW'(i));
            sw_hit[i] = Replay_Complete && Replay_Complete_SW_LWbar
                        && (Replay_Complete_ScbID == IDW'(i));
            lw_hit[i] = Replay_Complete && !Replay_Complete_SW_LWbar
                        && (Replay_Complete_ScbID == IDW'(i));
            wb_hit[i] = 1'b0;
            for (int k = 0; k < NUM_WB; k++) begin
                if (Clear_Valid_regwr[k] && (Clear_ScbID_regwr[k*IDW +: IDW] == IDW'(i)))
                    wb_hit[i] = 1'b1;
            end
            free_hit[i] = valid_q[i] && (br_hit[i] || sw_hit[i]
                          || (wb_hit[i] && (done_q[i] || lw_hit[i]))
                          || (lw_hit[i] && wb_seen_q[i]));
        end
        valid_clr = valid_q & ~free_hit;
    end

    always_comb begin
        alloc_id = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_clr[i])
                alloc_id = IDW'(i);
        end
        full_clr   = &valid_clr;
        alloc_fire = RP_Grt && !full_clr;
        alloc_oh   = '0;
        if (alloc_fire)
            alloc_oh[alloc_id] = 1'b1;
        valid_next = valid_clr | alloc_oh;
        occ_next   = '0;
        for (int i = 0; i < DEPTH; i++)
            occ_next = occ_next + (IDW+1)'(valid_next[i]);
    end

    // Hazards are judged against the post-clear entries, so a same-cycle clear unblocks issue.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            hazard[i] = valid_clr[i] && (
                (dst_v_q[i] && Src1_Valid && (Src1 == dst_q[i])) ||
                (dst_v_q[i] && Src2_Valid && (Src2 == dst_q[i])) ||
                (dst_v_q[i] && Dst_Valid  && (Dst  == dst_q[i])) ||
                (src1_v_q[i] && Dst_Valid && (Dst  == src1_q[i])) ||
                (src2_v_q[i] && Dst_Valid && (Dst  == src2_q[i])));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= '0;
            done_q    <= '0;
            wb_seen_q <= '0;
            occ_q     <= '0;
        end else begin
            valid_q <= valid_next;
            occ_q   <= occ_next;
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    done_q[i]    <= !Replayable;
                    wb_seen_q[i] <= 1'b0;
                end else if (valid_clr[i]) begin
                    if (lw_hit[i])
                        done_q[i] <= 1'b1;
                    if (wb_hit[i])
                        wb_seen_q[i] <= 1'b1;
                end
            end
        end
    end

    // Operand fields are only meaningful while the entry is valid, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_oh[i]) begin
                dst_q[i]    <= Dst;
                src1_q[i]   <= Src1;
                src2_q[i]   <= Src2;
                dst_v_q[i]  <= Dst_Valid;
                src1_v_q[i] <= Src1_Valid;
                src2_v_q[i] <= Src2_Valid;
            end
        end
    end

    assign Full         = full_clr;
    assign Empty        = ~|valid_clr;
    assign Dep_Mask     = hazard;
    assign Dependent    = |hazard;
    assign ScbID_Scb_IB = alloc_id;
    assign Occupancy    = occ_q;

`ifdef SCB_WATCHDOG_EN
    localparam int AGE_W = $clog2(TIMEOUT + 1);

    logic [AGE_W-1:0] age_q    [DEPTH];
    logic [AGE_W-1:0] age_next [DEPTH];
    logic [DEPTH-1:0] expired;
    logic [IDW-1:0]   expired_id;
    logic             timeout_q;
    logic [IDW-1:0]   timeout_id_q;

    // Age counts cycles an entry has stayed resident and saturates at the threshold.
    always_comb begin
        expired_id = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (alloc_oh[i] || !valid_clr[i])
                age_next[i] = '0;
            else if (age_q[i] == AGE_W'(TIMEOUT))
                age_next[i] = age_q[i];
            else
                age_next[i] = age_q[i] + AGE_W'(1);
            expired[i] = valid_next[i] && (age_next[i] == AGE_W'(TIMEOUT));
        end
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (expired[i])
                expired_id = IDW'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                age_q[i] <= '0;
            timeout_q    <= 1'b0;
            timeout_id_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                age_q[i] <= age_next[i];
            timeout_q    <= |expired;
            timeout_id_q <= expired_id;
        end
    end

    assign Timeout       = timeout_q;
    assign Timeout_ScbID = timeout_id_q;
`else
    assign Timeout       = 1'b0;
    assign Timeout_ScbID = '0;
`endif

endmodule

// File: doc/scoreboard_warp_param.md
# scoreboard_warp_param

Parametrised per-warp scoreboard that tracks in-flight instructions issued from the IBuffer and blocks issue of any instruction with a RAW/WAW/WAR hazard against them. It generalises the 4-entry scoreboard to DEPTH entries, configurable register-ID width and multiple CDB writeback clear ports. It adds order-independent LW completion (CDB writeback may arrive before or after Replay_Complete), per-entry dependency reporting, an occupancy count and an optional stuck-entry watchdog. Sits between the IBuffer/Issue unit and the ALU/MEM/CDB clear sources, one instance per warp.

## Interface
- DEPTH, 4: number of entries; power of two, ≥2. Localparam IDW = $clog2(DEPTH).
- REG_W, 5: register-ID width.
- NUM_WB, 1: number of CDB writeback clear ports.
- TIMEOUT, 1023: watchdog threshold in cycles (only used with SCB_WATCHDOG_EN).
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, synchronous, active-high.
- Src1, Src2, Dst  in  REG_W each  operand IDs of the candidate instruction.
- Src1_Valid, Src2_Valid, Dst_Valid  in  1 each  operand used.
- RP_Grt  in  1  issue grant; allocate an entry for the candidate.
- Replayable  in  1  candidate is LW/SW; entry starts incomplete.
- Replay_Complete  in  1; Replay_Complete_ScbID  in  IDW; Replay_Complete_SW_LWbar  in  1  memory replay finished (1 = SW).
- Clear_Valid_Br  in  1; Clear_ScbID_Br  in  IDW  branch resolution clear from ALU.
- Clear_Valid_regwr  in  NUM_WB; Clear_ScbID_regwr  in  NUM_WB*IDW  CDB writeback clears, port k at bits [k*IDW +: IDW].
- Full, Empty, Dependent  out  1 each.
- ScbID_Scb_IB  out  IDW  entry to be allocated on RP_Grt.
- Dep_Mask  out  DEPTH  per-entry hazard hits.
- Occupancy  out  IDW+1  registered count of valid entries.
- Timeout  out  1; Timeout_ScbID  out  IDW  watchdog (macro only).

## Operation
- Per-entry state: Valid, Done (replay complete), Wb_Seen, stored operand IDs/valids.
- Allocation: on RP_Grt, entry = lowest index free in the cleared vector; Valid=1, Done=~Replayable, Wb_Seen=0, operands captured. RP_Grt while Full: ignored, no state change.
- Cleared vector (combinational) removes an entry when any holds this cycle: branch clear; SW Replay_Complete; regwr clear with (Done or Wb_Seen-equivalent: Replay_Complete for same ID this cycle); regwr clear or Replay_Complete(LW) completing an entry whose other half already arrived (Done & regwr, or Wb_Seen & LW Replay_Complete).
- LW regwr clear while not Done: entry stays valid, Wb_Seen←1. LW Replay_Complete without regwr: Done←1.
- Clears to a free entry: ignored. Multiple clears to one entry: freed once.
- Hazard per valid-after-clear entry i: RAW (candidate Src vs Dst[i]), WAW (Dst vs Dst[i]), WAR (Dst vs Src1/Src2[i]), each gated by both valid bits. Dep_Mask[i] = result; Dependent = |Dep_Mask.
- Full = all cleared entries valid; Empty = none valid.
- Occupancy = popcount of next Valid vector, registered.

## Timing
- Clears affect Full, Empty, Dependent, Dep_Mask, ScbID_Scb_IB combinationally the same cycle (one-cycle saving); freed slot is reallocatable in that cycle.
- Allocated entry visible to hazard checks from the next cycle.
- Reset: all Valid/Done/Wb_Seen=0; Full=0, Empty=1, Dependent=0, Dep_Mask=0, ScbID_Scb_IB=0, Occupancy=0, Timeout=0, Timeout_ScbID=0. Reset mid-operation drops all entries.

## Configuration
- SCB_WATCHDOG_EN defined: per-entry saturating age counter, cleared on allocate, increments while valid; Timeout registered high when any counter reaches TIMEOUT, Timeout_ScbID = lowest such index; clears when entry frees.
- Undefined: no counters; Timeout and Timeout_ScbID tied 0.

## Test plan
- Reset, then RP_Grt with Dst=3 -> ScbID_Scb_IB=0, next cycle Occupancy=1, candidate Src1=3 valid -> Dependent=1, Dep_Mask=0001.
- Fill DEPTH=4 -> Full=1; RP_Grt ignored; branch clear ID 2 same cycle -> Full=0, ScbID_Scb_IB=2.
- LW at ID 1: regwr clear first (entry stays, Dependent still 1), Replay_Complete LW two cycles later -> freed that cycle; repeat with reverse order -> same.
- NUM_WB=2, both ports clear IDs 0 and 3 same cycle -> both freed, Occupancy drops by 2.
- WAR: entry Src2=7, candidate Dst=7 -> Dependent=1; Dst_Valid=0 -> Dependent=0.
- SCB_WATCHDOG_EN, TIMEOUT=8: hold entry 0 valid 8 cycles -> Timeout=1, Timeout_ScbID=0; clear -> Timeout=0.
